branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Direct-mapped branch history table (BHT) with a target buffer.
//  Fetch uses the lookup side; the branch resolver drives the update side.
//  The update side carries the resolver's feedback enable, actual direction, branch PC,
//  taken target and mispredict flag.
//  The lookup side returns pred_out, which becomes the resolver's prediction input two
//  stages later, and target_out, which steers the fetch PC mux when the branch is
//  predicted taken.
// PARAMETERS
//  DATA_WIDTH    32     address/data width
//  INDEX_WIDTH   4      log2 of entry count (16 entries)
//  CNT_INIT      2'b01  counter value at reset and on not-taken allocate (weakly not-taken)
// PORTS
//  clk_in             in   1             clock, all state updates on rising edge
//  rst_n_in           in   1             asynchronous reset, active-low
//  lookup_pc_in       in   DATA_WIDTH    fetch PC to predict
//  pred_out           out  1             1 = predicted taken
//  hit_out            out  1             lookup PC present in table
//  target_out         out  DATA_WIDTH    predicted target (valid when pred_out=1)
//  update_enable_in   in   1             resolver feedback valid (one branch per cycle)
//  update_taken_in    in   1             actual branch direction
//  update_mispred_in  in   1             resolver flushed for this branch
//  update_pc_in       in   DATA_WIDTH    PC of the resolved branch
//  update_target_in   in   DATA_WIDTH    pc+imm of the resolved branch
//  mispred_count_out  out  32            saturating mispredict counter
// BEHAVIOUR
//  - Address fields
//    - index = pc[INDEX_WIDTH+1:2]
//    - tag = pc[DATA_WIDTH-1:INDEX_WIDTH+2]
//    - pc[1:0] is ignored.
//  - Per-entry state: valid (1 bit), tag, target (DATA_WIDTH bits), cnt (2-bit saturating counter).
//  - Lookup is combinational, with zero latency.
//    - hit_out = valid[idx] && tag[idx] == lookup tag.
//    - pred_out = hit_out && cnt[idx][1].
//    - target_out = target[idx] when pred_out=1, else 0.
//  - Update happens on the rising edge when update_enable_in=1; otherwise the table holds.
//    - Hit (valid and tag match), taken: cnt = min(cnt+1, 3); target is overwritten
//      with update_target_in.
//    - Hit, not taken: cnt = max(cnt-1, 0); target is unchanged.
//    - Miss or invalid entry: allocate (replace) the entry.
//      - valid=1, tag written.
//      - cnt = 2'b10 if taken, else CNT_INIT.
//      - target = update_target_in if taken, else 0.
//  - Counter FSM: 00 SNT <-> 01 WNT <-> 10 WT <-> 11 ST.
//    - Taken moves right; not-taken moves left.
//    - Saturates at both ends, with no wrap-around.
//  - mispred_count_out
//    - Increments by 1 on a clock edge where update_enable_in && update_mispred_in.
//    - Saturates at 32'hFFFFFFFF and never wraps.
//    - update_mispred_in is ignored while update_enable_in=0.
//  - Same-cycle lookup and update to the same index is read-before-write.
//    - The lookup returns the pre-update entry.
//    - The new value is visible from the next cycle.
//  - Reset (asynchronous, takes effect immediately, also mid-operation)
//    - All valid bits = 0, cnt = CNT_INIT, tag = 0, target = 0, mispred_count_out = 0.
//    - Hence pred_out = 0, hit_out = 0, target_out = 0 while rst_n_in = 0.
//    - An update presented in the reset-release cycle is applied on the first rising
//      edge where rst_n_in = 1.
//  - No handshake or back-pressure: every enabled update is accepted in one cycle.
// TESTING
//  - Reset: assert rst_n_in=0 mid-stream after filling 4 entries
//    -> pred_out=0, hit_out=0, mispred_count_out=0 immediately; all lookups miss after release.
//  - Allocate taken: update pc=0x100, taken=1, target=0x140
//    -> next cycle lookup 0x100: hit=1, pred=1, target_out=0x140.
//  - Saturation: 3 more taken updates on 0x100, then 1 not-taken -> pred stays 1 (cnt 11->10).
//    - A 2nd not-taken gives pred=0 (cnt 01).
//    - 5 further not-takens hold cnt at 00.
//  - Alias/replace: after allocating 0x100, update pc=0x140 (same index 0, different tag)
//    - Taken=0 -> lookup 0x100 misses.
//    - Lookup 0x140: hit=1, pred=0.
//  - Same-cycle collision: entry 0x100 at cnt 01; update taken on 0x100 while looking up
//    0x100 -> pred_out=0 that cycle, 1 the next cycle.
//  - Mispredict counter: 7 enabled updates with mispred=1, plus 2 with enable=0 and
//    mispred=1 -> count=7.
//    - Force-preload 32'hFFFFFFFE, then 3 mispredicts -> count=32'hFFFFFFFF.

Source files
------------

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and resolver update bundle for the branch predictor.
//   lookup_pc_in      fetch PC to predict
//   pred_out          1 = predicted taken
//   hit_out           lookup PC present in table
//   target_out        predicted target, 0 unless pred_out
//   update_enable_in  resolver feedback valid
//   update_taken_in   actual branch direction
//   update_mispred_in resolver flushed for this branch
//   update_pc_in      PC of the resolved branch
//   update_target_in  taken target of the resolved branch
//   mispred_count_out saturating mispredict counter
// master = fetch/resolver side, slave = predictor side.
interface branch_predictor_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] lookup_pc_in;
    logic                  pred_out;
    logic                  hit_out;
    logic [DATA_WIDTH-1:0] target_out;
    logic                  update_enable_in;
    logic                  update_taken_in;
    logic                  update_mispred_in;
    logic [DATA_WIDTH-1:0] update_pc_in;
    logic [DATA_WIDTH-1:0] update_target_in;
    logic [31:0]           mispred_count_out;
    modport master (
        output lookup_pc_in, update_enable_in, update_taken_in, update_mispred_in,
               update_pc_in, update_target_in,
        input  pred_out, hit_out, target_out, mispred_count_out
    );
    modport slave (
        input  lookup_pc_in, update_enable_in, update_taken_in, update_mispred_in,
               update_pc_in, update_target_in,
        output pred_out, hit_out, target_out, mispred_count_out
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit-counter branch history table with target buffer.
//   clk_in    clock, all state updates on rising edge
//   rst_n_in  asynchronous active-low reset
//   bus       branch_predictor_if.slave: combinational lookup, one update per cycle,
//             saturating mispredict counter
module branch_predictor #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         INDEX_WIDTH = 4,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    branch_predictor_if.slave   bus
);
    localparam int N  = 1 << INDEX_WIDTH;
    localparam int TW = DATA_WIDTH - INDEX_WIDTH - 2;

    logic          valid_mem  [N];
    logic [TW-1:0] tag_mem    [N];
    logic [DATA_WIDTH-1:0] target_mem [N];
    logic [1:0]    cnt_mem    [N];
    logic [31:0]   mispred_count;

    logic [INDEX_WIDTH-1:0] l_idx, u_idx;
    logic [TW-1:0]          l_tag, u_tag;
    logic                   u_hit;
    logic [1:0]             u_cnt, u_cnt_next;
    logic                   unused_pc_bits;

    assign l_idx = bus.lookup_pc_in[INDEX_WIDTH+1:2];
    assign l_tag = bus.lookup_pc_in[DATA_WIDTH-1:INDEX_WIDTH+2];
    assign u_idx = bus.update_pc_in[INDEX_WIDTH+1:2];
    assign u_tag = bus.update_pc_in[DATA_WIDTH-1:INDEX_WIDTH+2];
    assign unused_pc_bits = ^{bus.lookup_pc_in[1:0], bus.update_pc_in[1:0]};

    // Lookup reads the stored entry, so a same-cycle update is seen only next cycle.
    always_comb begin
        bus.hit_out    = valid_mem[l_idx] && tag_mem[l_idx] == l_tag;
        bus.pred_out   = bus.hit_out && cnt_mem[l_idx][1];
        bus.target_out = bus.pred_out ? target_mem[l_idx] : '0;
    end

    always_comb begin
        u_hit      = valid_mem[u_idx] && tag_mem[u_idx] == u_tag;
        u_cnt      = cnt_mem[u_idx];
        u_cnt_next = bus.update_taken_in ? (u_cnt == 2'b11 ? 2'b11 : u_cnt + 2'd1)
                                         : (u_cnt == 2'b00 ? 2'b00 : u_cnt - 2'd1);
    end

    assign bus.mispred_count_out = mispred_count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < N; i++) begin
                valid_mem[i]  <= 1'b0;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                cnt_mem[i]    <= CNT_INIT;
            end
            mispred_count <= '0;
        end else begin
            if (bus.update_enable_in) begin
                if (u_hit) begin
                    cnt_mem[u_idx] <= u_cnt_next;
                    if (bus.update_taken_in)
                        target_mem[u_idx] <= bus.update_target_in;
                end else begin
                    valid_mem[u_idx]  <= 1'b1;
                    tag_mem[u_idx]    <= u_tag;
                    cnt_mem[u_idx]    <= bus.update_taken_in ? 2'b10 : CNT_INIT;
                    target_mem[u_idx] <= bus.update_taken_in ? bus.update_target_in : '0;
                end
            end
            if (bus.update_enable_in && bus.update_mispred_in && mispred_count != '1)
                mispred_count <= mispred_count + 32'd1;
        end
    end
endmodule
